// File: rtl/misr_bist_ctrl_if.sv
// misr_bist_ctrl_if: start/config, DUT response, MISR and result signals of the BIST sequencer
interface misr_bist_ctrl_if #(
   parameter int NUM_BITS = 54,
   parameter int CNT_W = 16
);
   logic                i_start;
   logic [CNT_W-1:0]    i_num_beats;
   logic [NUM_BITS-1:0] i_seed;
   logic [NUM_BITS-1:0] i_golden;
   logic                i_dut_vld;
   logic [NUM_BITS-1:0] i_dut_data;
   logic                o_dut_rdy;
   logic                o_misr_en;
   logic                o_misr_load;
   logic [NUM_BITS-1:0] o_misr_din;
   logic                i_misr_vld;
   logic [NUM_BITS-1:0] i_misr_data;
   logic                o_busy;
   logic                o_done;
   logic                o_pass;
   logic [NUM_BITS-1:0] o_signature;
   logic                o_timeout;
   modport master (
      input  i_start, i_num_beats, i_seed, i_golden, i_dut_vld, i_dut_data, i_misr_vld, i_misr_data,
      output o_dut_rdy, o_misr_en, o_misr_load, o_misr_din, o_busy, o_done, o_pass, o_signature, o_timeout
   );
   modport slave (
      output i_start, i_num_beats, i_seed, i_golden, i_dut_vld, i_dut_data, i_misr_vld, i_misr_data,
      input  o_dut_rdy, o_misr_en, o_misr_load, o_misr_din, o_busy, o_done, o_pass, o_signature, o_timeout
   );
endinterface

// File: rtl/misr_bist_ctrl.sv
// misr_bist_ctrl: seeds the MISR, gates response beats into it and checks the final signature.
// Define MISR_BIST_TIMEOUT_EN to enable the RUN-state stall watchdog.
module misr_bist_ctrl #(
   parameter int NUM_BITS = 54,
   parameter int CNT_W = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic i_clk,
   input logic i_rst,
   misr_bist_ctrl_if.master bus
);
`ifdef MISR_BIST_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [2:0] {IDLE, SEED, RUN, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0] rem;
   logic [NUM_BITS-1:0] seed, golden;
   logic [WD_W-1:0] wd;
   logic wd_hit;
   logic last_beat;
   assign last_beat = bus.i_dut_vld && rem == CNT_W'(1);
   assign wd_hit = WD_EN && state == RUN && !bus.i_dut_vld && wd == WD_W'(TIMEOUT_CYC - 1);
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = bus.i_start ? SEED : IDLE;
         SEED:    state_nxt = rem != '0 ? RUN : DRAIN;
         RUN:     state_nxt = wd_hit ? DONE : last_beat ? DRAIN : RUN;
         DRAIN:   state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
   assign bus.o_dut_rdy = state == RUN;
   assign bus.o_misr_en = state == SEED || (state == RUN && bus.i_dut_vld);
   assign bus.o_misr_load = state == SEED;
   assign bus.o_misr_din = state == SEED ? seed : bus.i_dut_data;
   assign bus.o_busy = state != IDLE;
   assign bus.o_done = state == DONE;
   // watchdog counts consecutive stalled RUN cycles; any accepted beat clears it
   always_ff @(posedge i_clk)
      wd <= (i_rst || state != RUN || bus.i_dut_vld) ? '0 : wd + WD_W'(1);
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         rem <= '0;
         seed <= '0;
         golden <= '0;
         bus.o_pass <= 1'b0;
         bus.o_signature <= '0;
         bus.o_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.i_start) begin
            rem <= bus.i_num_beats;
            seed <= bus.i_seed;
            golden <= bus.i_golden;
            bus.o_pass <= 1'b0;
            bus.o_timeout <= 1'b0;
         end
         if (state == RUN && bus.i_dut_vld)
            rem <= rem - CNT_W'(1);
         if (state == DRAIN) begin
            bus.o_signature <= bus.i_misr_data;
            bus.o_pass <= bus.i_misr_vld && bus.i_misr_data == golden;
         end
         if (wd_hit) begin
            bus.o_timeout <= 1'b1;
            bus.o_pass <= 1'b0;
            bus.o_signature <= '0;
         end
      end
   end
endmodule

// File: tb/tb_misr_bist_ctrl.sv
// tb_misr_bist_ctrl: randomized bench with a behavioural MISR and a signature reference model.
module tb_misr_bist_ctrl;
   localparam int NB = 54;
   localparam logic [NB-1:0] TAPS = (54'd1 << 53) | (54'd1 << 52) | (54'd1 << 17) | (54'd1 << 16);
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [NB-1:0] beats[$];
   bit vpat[$];
   logic [NB-1:0] misr_q;
   logic misr_v;
   misr_bist_ctrl_if #(.NUM_BITS(NB), .CNT_W(16)) bus ();
   misr_bist_ctrl #(.NUM_BITS(NB), .CNT_W(16), .TIMEOUT_CYC(8)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [NB-1:0] misr_step(input logic [NB-1:0] s, input logic [NB-1:0] d);
      return {s[NB-2:0], ^(s & TAPS)} ^ d;
   endfunction
   function automatic logic [NB-1:0] model_sig(input logic [NB-1:0] sd);
      logic [NB-1:0] s = sd;
      foreach (beats[i]) s = misr_step(s, beats[i]);
      return s;
   endfunction
   function automatic logic [NB-1:0] rnd54();
      logic [63:0] t = {$urandom, $urandom};
      return t[NB-1:0];
   endfunction
   // external MISR device
   always @(posedge clk) begin
      if (rst) begin
         misr_q <= '0;
         misr_v <= 1'b0;
      end else if (bus.o_misr_en) begin
         misr_q <= bus.o_misr_load ? bus.o_misr_din : misr_step(misr_q, bus.o_misr_din);
         misr_v <= 1'b1;
      end
   end
   assign bus.i_misr_data = misr_q;
   assign bus.i_misr_vld = misr_v;
   task automatic gen(input int n, input bit all_vld);
      int ones = 0;
      beats = {};
      vpat = {};
      for (int i = 0; i < n; i++) beats.push_back(rnd54());
      while (ones < n) begin
         bit b = all_vld || ($urandom_range(0, 2) != 0);
         vpat.push_back(b);
         ones += int'(b);
      end
   endtask
   task automatic run_seq(input int n, input logic [NB-1:0] sd, input logic [NB-1:0] gd, input int maxcyc,
                          output int done_cyc, output int en_cnt, output int load_cnt, output int load_first,
                          output logic pass_o, output logic [NB-1:0] sig_o, output logic to_o);
      int k = 0;
      done_cyc = -1;
      en_cnt = 0;
      load_cnt = 0;
      load_first = -1;
      pass_o = 1'bx;
      sig_o = 'x;
      to_o = 1'bx;
      bus.i_num_beats = 16'(n);
      bus.i_seed = sd;
      bus.i_golden = gd;
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      for (int c = 1; c <= maxcyc && done_cyc < 0; c++) begin
         bus.i_dut_vld = (c >= 2 && c - 2 < vpat.size() && k < beats.size()) ? vpat[c-2] : 1'b0;
         bus.i_dut_data = bus.i_dut_vld ? beats[k] : rnd54();
         #1;
         en_cnt += int'(bus.o_misr_en);
         if (bus.o_misr_load) begin
            load_cnt++;
            if (load_first < 0) load_first = c;
         end
         if (bus.i_dut_vld && bus.o_dut_rdy) k++;
         if (bus.o_done) begin
            done_cyc = c;
            pass_o = bus.o_pass;
            sig_o = bus.o_signature;
            to_o = bus.o_timeout;
         end
         @(posedge clk);
         #1;
      end
      bus.i_dut_vld = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      bus.i_dut_vld = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if ({bus.o_busy, bus.o_done, bus.o_pass, bus.o_timeout, bus.o_misr_en, bus.o_misr_load, bus.o_dut_rdy} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b want=0", {bus.o_busy, bus.o_done, bus.o_pass, bus.o_timeout, bus.o_misr_en, bus.o_misr_load, bus.o_dut_rdy});
      end
      checks++;
      if (bus.o_signature !== '0) begin
         errors++;
         $display("FAIL reset_sig got=%h want=0", bus.o_signature);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.i_dut_vld = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic test_zero_beats;
      int dc, en, ld, lf;
      logic p, t;
      logic [NB-1:0] s;
      gen(0, 1'b1);
      run_seq(0, 54'h15555555555555, 54'h15555555555555, 20, dc, en, ld, lf, p, s, t);
      checks++;
      if (dc !== 3) begin errors++; $display("FAIL zero_done_cycle got=%0d want=3", dc); end
      checks++;
      if (s !== 54'h15555555555555) begin errors++; $display("FAIL zero_sig got=%h want=15555555555555", s); end
      checks++;
      if (p !== 1'b1) begin errors++; $display("FAIL zero_pass got=%b want=1", p); end
      checks++;
      if (en !== 1 || ld !== 1) begin errors++; $display("FAIL zero_en_load got=%0d/%0d want=1/1", en, ld); end
   endtask
   task automatic test_four_beats;
      int dc, en, ld, lf;
      logic p, t;
      logic [NB-1:0] s, exp_s;
      gen(4, 1'b1);
      foreach (beats[i]) beats[i] = NB'(i + 1);
      exp_s = model_sig('0);
      for (int g = 0; g < 2; g++) begin
         run_seq(4, '0, exp_s ^ NB'(g), 30, dc, en, ld, lf, p, s, t);
         checks++;
         if (dc !== 7) begin errors++; $display("FAIL four_done_cycle[%0d] got=%0d want=7", g, dc); end
         checks++;
         if (en !== 5 || ld !== 1 || lf !== 1) begin
            errors++;
            $display("FAIL four_en_load[%0d] got=en%0d ld%0d at%0d want=en5 ld1 at1", g, en, ld, lf);
         end
         checks++;
         if (s !== exp_s) begin errors++; $display("FAIL four_sig[%0d] got=%h want=%h", g, s, exp_s); end
         checks++;
         if (p !== (g == 0)) begin errors++; $display("FAIL four_pass[%0d] got=%b want=%b", g, p, g == 0); end
         checks++;
         if (bus.o_pass !== (g == 0) || bus.o_done !== 1'b0 || bus.o_signature !== exp_s) begin
            errors++;
            $display("FAIL four_hold[%0d] got=pass%b done%b want=pass%b done0", g, bus.o_pass, bus.o_done, g == 0);
         end
      end
   endtask
   task automatic test_stalls;
      int dc, en, ld, lf;
      logic p, t;
      logic [NB-1:0] s, exp_s;
      gen(3, 1'b1);
      vpat = {1, 0, 0, 1, 0, 1};
      exp_s = model_sig(54'h2a);
      run_seq(3, 54'h2a, exp_s, 30, dc, en, ld, lf, p, s, t);
      checks++;
      if (dc !== 9) begin errors++; $display("FAIL stall_done_cycle got=%0d want=9", dc); end
      checks++;
      if (en !== 4) begin errors++; $display("FAIL stall_en_count got=%0d want=4", en); end
      checks++;
      if (s !== exp_s || p !== 1'b1) begin errors++; $display("FAIL stall_sig got=%h pass%b want=%h pass1", s, p, exp_s); end
   endtask
   task automatic test_random;
      int dc, en, ld, lf, n;
      logic p, t, want_p;
      logic [NB-1:0] s, sd, exp_s;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(0, 12);
         gen(n, 1'b0);
         sd = rnd54();
         exp_s = model_sig(sd);
         want_p = $urandom_range(0, 1) == 1;
         run_seq(n, sd, want_p ? exp_s : exp_s ^ (NB'(1) << $urandom_range(0, NB - 1)), 80, dc, en, ld, lf, p, s, t);
         checks++;
         if (dc !== 3 + vpat.size()) begin errors++; $display("FAIL rand_done_cycle[%0d] got=%0d want=%0d", it, dc, 3 + vpat.size()); end
         checks++;
         if (en !== n + 1) begin errors++; $display("FAIL rand_en_count[%0d] got=%0d want=%0d", it, en, n + 1); end
         checks++;
         if (s !== exp_s || p !== want_p) begin
            errors++;
            $display("FAIL rand_result[%0d] got=%h pass%b want=%h pass%b", it, s, p, exp_s, want_p);
         end
      end
   endtask
   task automatic test_start_rst;
      int dc, en, ld, lf;
      logic p, t;
      logic [NB-1:0] s, exp_s;
      gen(6, 1'b1);
      bus.i_num_beats = 16'd6;
      bus.i_seed = rnd54();
      bus.i_golden = '0;
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_dut_vld = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         bus.i_start = c == 3;
         bus.i_dut_data = rnd54();
         @(posedge clk);
         #1;
      end
      bus.i_start = 1'b0;
      #1;
      checks++;
      if (bus.o_misr_load !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_dut_rdy !== 1'b1) begin
         errors++;
         $display("FAIL restart_ignored got=load%b busy%b rdy%b want=load0 busy1 rdy1", bus.o_misr_load, bus.o_busy, bus.o_dut_rdy);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.o_busy, bus.o_done, bus.o_pass, bus.o_timeout, bus.o_misr_en, bus.o_misr_load, bus.o_dut_rdy} !== 7'b0 || bus.o_signature !== '0) begin
         errors++;
         $display("FAIL midrun_reset got=%b sig=%h want=0",
                  {bus.o_busy, bus.o_done, bus.o_pass, bus.o_timeout, bus.o_misr_en, bus.o_misr_load, bus.o_dut_rdy}, bus.o_signature);
      end
      bus.i_dut_vld = 1'b0;
      gen(2, 1'b1);
      exp_s = model_sig(54'h3);
      run_seq(2, 54'h3, exp_s, 20, dc, en, ld, lf, p, s, t);
      checks++;
      if (dc !== 5 || s !== exp_s || p !== 1'b1) begin
         errors++;
         $display("FAIL fresh_run got=cyc%0d %h pass%b want=cyc5 %h pass1", dc, s, p, exp_s);
      end
   endtask
   task automatic test_max_count;
      int dc, en, ld, lf;
      logic p, t;
      logic [NB-1:0] s, exp_s;
      gen(65535, 1'b1);
      exp_s = model_sig(54'h1);
      run_seq(65535, 54'h1, exp_s, 65600, dc, en, ld, lf, p, s, t);
      checks++;
      if (dc !== 65538 || s !== exp_s || p !== 1'b1) begin
         errors++;
         $display("FAIL max_count got=cyc%0d %h pass%b want=cyc65538 %h pass1", dc, s, p, exp_s);
      end
   endtask
   task automatic test_watchdog;
      int dc, en, ld, lf;
      logic p, t;
      logic [NB-1:0] s;
      gen(5, 1'b1);
      vpat = {1, 1};
`ifdef MISR_BIST_TIMEOUT_EN
      run_seq(5, rnd54(), '0, 50, dc, en, ld, lf, p, s, t);
      checks++;
      if (dc !== 12) begin errors++; $display("FAIL wd_done_cycle got=%0d want=12", dc); end
      checks++;
      if (t !== 1'b1 || p !== 1'b0 || s !== '0) begin
         errors++;
         $display("FAIL wd_result got=to%b pass%b sig%h want=to1 pass0 sig0", t, p, s);
      end
      checks++;
      if (en !== 3) begin errors++; $display("FAIL wd_en_count got=%0d want=3", en); end
`else
      run_seq(5, rnd54(), '0, 102, dc, en, ld, lf, p, s, t);
      checks++;
      if (dc !== -1 || bus.o_busy !== 1'b1 || bus.o_timeout !== 1'b0) begin
         errors++;
         $display("FAIL no_wd_hang got=done%0d busy%b to%b want=none busy1 to0", dc, bus.o_busy, bus.o_timeout);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
`endif
   endtask
   initial begin
      bus.i_start = 1'b0;
      bus.i_num_beats = '0;
      bus.i_seed = '0;
      bus.i_golden = '0;
      bus.i_dut_vld = 1'b0;
      bus.i_dut_data = '0;
      test_reset();
      test_zero_beats();
      test_four_beats();
      test_stalls();
      test_random();
      test_start_rst();
      test_watchdog();
      test_max_count();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
